regbank_access_ctrl: RTL and testbench
======================================

Name: regbank_access_ctrl

Overview:
- Initiator side of the working-register bank interface.
- The bank exposes one shared address (addr), a write enable (CE), write data (data_in) and combinational read data (data_out).
- This block sequences operand fetches (two sources) and result write-backs onto that single port.
- It sits between the control unit/ALU and the 32-entry register bank.

Parameters:
ADDR_W, 5, register address width (bank depth 2**ADDR_W)
DATA_W, 16, register data width

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
fetch_req  input  1  request to read src_a and src_b; held high until fetch_ack
src_a  input  ADDR_W  first operand address, sampled on acceptance
src_b  input  ADDR_W  second operand address, sampled on acceptance
fetch_ack  output  1  combinational; high in the cycle a fetch is accepted
op_valid  output  DATA_W-independent 1  operands op_a/op_b valid
op_ready  input  1  consumer takes operands when op_valid & op_ready
op_a  output  DATA_W  operand read from src_a
op_b  output  DATA_W  operand read from src_b
wb_req  input  1  write-back request; held high until wb_ack
wb_addr  input  ADDR_W  destination register, sampled on acceptance
wb_data  input  DATA_W  write data, sampled on acceptance
wb_ack  output  1  combinational; high in the cycle a write-back is accepted
reg_addr  output  ADDR_W  to bank addr
reg_CE  output  1  to bank CE
reg_wdata  output  DATA_W  to bank data_in
reg_rdata  input  DATA_W  from bank data_out
busy  output  1  state != IDLE

Behaviour:
- Reset (async, RST_N=0): state=IDLE, reg_CE=0, reg_addr=0, reg_wdata=0, op_valid=0, op_a=op_b=0. Any in-flight fetch or write is dropped.
- All outputs except fetch_ack/wb_ack are registered (driven from state and latched registers).
- States: IDLE, WRITE, FETCH_A, FETCH_B, HOLD.
- IDLE arbitration:
  - wb_req has priority.
  - wb_req=1: wb_ack=1, latch wb_addr/wb_data, go to WRITE.
  - else fetch_req=1: fetch_ack=1, latch src_a/src_b, go to FETCH_A.
  - else stay in IDLE.
  - Requests are never acked outside IDLE.
- WRITE (1 cycle): reg_addr=latched wb_addr, reg_wdata=latched data, reg_CE=1. Next state IDLE. Bank contents update at the end of this cycle.
- FETCH_A (1 cycle): reg_addr=latched src_a, reg_CE=0; op_a<=reg_rdata at the clock edge. Next state FETCH_B.
- FETCH_B (1 cycle): reg_addr=latched src_b, reg_CE=0; op_b<=reg_rdata. Next state HOLD.
- HOLD: op_valid=1. op_a/op_b are stable until op_valid & op_ready, then go to IDLE with op_valid=0. op_a/op_b keep their values until the next fetch overwrites them.
- reg_CE is 1 only in WRITE; in all other states reg_CE=0.
- Latency:
  - Fetch accepted in cycle T: FETCH_A in T+1, FETCH_B in T+2, op_valid in T+3.
  - Write accepted in T: CE in T+1; value readable from T+2.
  - Minimum fetch turnaround: 4 cycles.
- Ordering: a write accepted before a fetch is always visible to that fetch (read-after-write safe), because the write completes before IDLE is re-entered.
- src_a == src_b: both operands return the same value; this is legal.
- Simultaneous wb_req and fetch_req in IDLE: write first, then the fetch is accepted on the next IDLE cycle (earliest T+2).
- Starvation: continuous wb_req indefinitely delays fetches. This is accepted behaviour; the control unit guarantees write gaps.
- Address wrap: addresses are ADDR_W bits; there are no out-of-range values.

Optional Feature:
REG0_ZERO_EN
- Defined:
  - Register 0 is hard zero.
  - A write-back with wb_addr==0 is acked and passes through WRITE, but reg_CE stays 0.
  - A fetch of address 0 loads 0 into op_a/op_b regardless of reg_rdata.
- Undefined: register 0 behaves as a general-purpose register.

Test Plan:
- Reset mid-WRITE (RST_N low while reg_CE=1) -> reg_CE=0 and busy=0 immediately; bank entry unchanged; op_valid=0.
- wb_req addr=5 data=16'hA5A5, then fetch src_a=5 src_b=5 -> reg_CE high exactly one cycle with reg_addr=5; op_valid 3 cycles after fetch_ack; op_a=op_b=16'hA5A5.
- wb_req and fetch_req both high in the same IDLE cycle (write addr=3 data=16'h1234, fetch src_a=3 src_b=7, reg7=16'h0F0F) -> wb_ack first, fetch_ack 2 cycles later; op_a=16'h1234, op_b=16'h0F0F.
- op_ready held low 5 cycles in HOLD -> op_valid stays 1, op_a/op_b stable, fetch_ack and wb_ack stay 0 despite pending requests; on op_ready=1, IDLE next cycle.
- Back-to-back fetches (src 1,2 then 3,4) with op_ready tied 1 -> each fetch returns correct data; second fetch_ack exactly 4 cycles after the first.
- With REG0_ZERO_EN: write 16'hFFFF to addr 0, then fetch src_a=0 -> reg_CE never asserted, op_a=0; without the macro, op_a=16'hFFFF.

Source files
------------

// File: rtl/regbank_access_ctrl.sv
// -----------------------------------------------------------------------------
// regbank_access_ctrl
//
// Initiator side of the single-port working-register bank. Sequences operand
// fetches (two sources, one per cycle) and result write-backs onto the one
// shared address/CE/data port of the 32-entry register bank.
//
// Optional build macro: REG0_ZERO_EN
//   Defined   : register 0 is hard zero. Write-backs to address 0 are acked and
//               walk through WRITE but never raise reg_CE; fetches of address 0
//               return 0 regardless of reg_rdata.
//   Undefined : register 0 is an ordinary register.
//
// Ports
//   CLK        in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   fetch_req  in   operand fetch request, held until fetch_ack
//   src_a      in   first operand address (sampled on acceptance)
//   src_b      in   second operand address (sampled on acceptance)
//   fetch_ack  out  combinational, high in the cycle a fetch is accepted
//   op_valid   out  op_a/op_b valid (HOLD state)
//   op_ready   in   consumer takes operands when op_valid & op_ready
//   op_a       out  operand read from src_a
//   op_b       out  operand read from src_b
//   wb_req     in   write-back request, held until wb_ack (wins over fetch)
//   wb_addr    in   destination register (sampled on acceptance)
//   wb_data    in   write data (sampled on acceptance)
//   wb_ack     out  combinational, high in the cycle a write-back is accepted
//   reg_addr   out  bank address
//   reg_CE     out  bank write enable, high only in WRITE
//   reg_wdata  out  bank write data
//   reg_rdata  in   bank combinational read data
//   busy       out  controller is not IDLE
// -----------------------------------------------------------------------------
module regbank_access_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    output logic              fetch_ack,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ack,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_CE,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy
);

`ifdef REG0_ZERO_EN
    localparam bit REG0_HARD = 1'b1;
`else
    localparam bit REG0_HARD = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        FETCH_A = 3'd2,
        FETCH_B = 3'd3,
        HOLD    = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ce_q, ce_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   src_b_q, src_b_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic                valid_q, valid_d;

    // A write to the hard-zero register must never reach the bank.
    function automatic logic wr_allowed(input logic [ADDR_W-1:0] a);
        return !(REG0_HARD && (a == '0));
    endfunction

    // Read data as seen by the consumer: the hard-zero register masks the bank.
    function automatic logic [DATA_W-1:0] rd_value(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] d);
        return (REG0_HARD && (a == '0)) ? '0 : d;
    endfunction

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ce_d      = 1'b0;
        wdata_d   = wdata_q;
        src_b_d   = src_b_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        valid_d   = valid_q;
        wb_ack    = 1'b0;
        fetch_ack = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Write-back wins so a fetch issued alongside it sees the new value.
                if (wb_req) begin
                    wb_ack  = 1'b1;
                    addr_d  = wb_addr;
                    wdata_d = wb_data;
                    ce_d    = wr_allowed(wb_addr);
                    state_d = WRITE;
                end else if (fetch_req) begin
                    fetch_ack = 1'b1;
                    addr_d    = src_a;
                    src_b_d   = src_b;
                    state_d   = FETCH_A;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            FETCH_A: begin
                // Bank read is combinational on reg_addr (= src_a this cycle).
                op_a_d  = rd_value(addr_q, reg_rdata);
                addr_d  = src_b_q;
                state_d = FETCH_B;
            end
            FETCH_B: begin
                op_b_d  = rd_value(addr_q, reg_rdata);
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (op_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ce_q    <= 1'b0;
            wdata_q <= '0;
            src_b_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ce_q    <= ce_d;
            wdata_q <= wdata_d;
            src_b_q <= src_b_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            valid_q <= valid_d;
        end
    end

    assign reg_addr  = addr_q;
    assign reg_CE    = ce_q;
    assign reg_wdata = wdata_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_valid  = valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for regbank_access_ctrl: a bank model driven by the DUT's port, a
// transaction-level reference model checked every cycle, directed scenarios
// with literal expectations, and a randomized traffic phase.
// -----------------------------------------------------------------------------
module tb_regbank_access_ctrl;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

`ifdef REG0_ZERO_EN
    localparam bit M_REG0 = 1'b1;
`else
    localparam bit M_REG0 = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          fetch_req;
    logic [AW-1:0] src_a, src_b;
    logic          fetch_ack;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op_a, op_b;
    logic          wb_req;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_ack;
    logic [AW-1:0] reg_addr;
    logic          reg_CE;
    logic [DW-1:0] reg_wdata;
    logic [DW-1:0] reg_rdata;
    logic          busy;

    regbank_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .fetch_req(fetch_req), .src_a(src_a), .src_b(src_b), .fetch_ack(fetch_ack),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
        .reg_addr(reg_addr), .reg_CE(reg_CE), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Register bank: combinational read, write on rising edge when CE.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] init_vals [DEPTH];
    logic          init_phase;
    assign reg_rdata = mem[reg_addr];
    always @(posedge CLK) begin
        if (init_phase) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_vals[i];
        end else if (reg_CE) begin
            mem[reg_addr] <= reg_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [DW-1:0] shadow [DEPTH];
    bit            chk_en = 1'b0;
    bit            in_fetch;
    int            free_cyc;
    int            valid_start;
    int            ce_cyc;
    bit            ce_en;
    logic [AW-1:0] ce_addr;
    logic [DW-1:0] ce_data;
    logic [DW-1:0] exp_a, exp_b;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        return (M_REG0 && a == 0) ? '0 : shadow[a];
    endfunction

    task automatic model_reset();
        in_fetch    = 1'b0;
        free_cyc    = 0;
        valid_start = 0;
        ce_cyc      = -1;
        ce_en       = 1'b0;
        exp_a       = '0;
        exp_b       = '0;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            bit idle, e_wb, e_f, e_ce, e_valid;
            idle    = !in_fetch && (cyc >= free_cyc);
            e_wb    = idle && wb_req;
            e_f     = idle && fetch_req && !wb_req;
            e_ce    = (cyc == ce_cyc) && ce_en;
            e_valid = in_fetch && (cyc >= valid_start);

            chk("m_wb_ack", 32'(wb_ack), 32'(e_wb));
            chk("m_fetch_ack", 32'(fetch_ack), 32'(e_f));
            chk("m_busy", 32'(busy), 32'(!idle));
            chk("m_reg_ce", 32'(reg_CE), 32'(e_ce));
            chk("m_op_valid", 32'(op_valid), 32'(e_valid));
            if (e_ce) begin
                chk("m_wr_addr", 32'(reg_addr), 32'(ce_addr));
                chk("m_wr_data", 32'(reg_wdata), 32'(ce_data));
                shadow[ce_addr] = ce_data;
            end
            if (e_valid || !in_fetch) begin
                chk("m_op_a", 32'(op_a), 32'(exp_a));
                chk("m_op_b", 32'(op_b), 32'(exp_b));
            end
            if (e_valid && op_ready) begin
                in_fetch = 1'b0;
                free_cyc = cyc + 1;
            end
            if (e_wb) begin
                ce_cyc   = cyc + 1;
                ce_en    = !(M_REG0 && wb_addr == 0);
                ce_addr  = wb_addr;
                ce_data  = wb_data;
                free_cyc = cyc + 2;
            end
            if (e_f) begin
                in_fetch    = 1'b1;
                valid_start = cyc + 3;
                exp_a       = model_read(src_a);
                exp_b       = model_read(src_b);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int t);
        @(posedge CLK); #1;
        wb_addr = a; wb_data = d; wb_req = 1'b1; t = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (wb_ack) begin
                t = cyc;
                break;
            end
            @(posedge CLK); #1;
        end
        if (t < 0) begin
            chk("wb_ack_timeout", 32'd0, 32'd1);
            @(posedge CLK); #1;
        end else begin
            @(posedge CLK); #1;
        end
        wb_req = 1'b0;
    endtask

    task automatic send_fetch(input logic [AW-1:0] a, input logic [AW-1:0] b, output int t);
        @(posedge CLK); #1;
        src_a = a; src_b = b; fetch_req = 1'b1; t = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (fetch_ack) begin
                t = cyc;
                break;
            end
            @(posedge CLK); #1;
        end
        if (t < 0) chk("fetch_ack_timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
        fetch_req = 1'b0;
    endtask

    task automatic wait_fetch_ack(output int t);
        t = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (fetch_ack) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("fetch_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(output int t);
        t = -1;
        for (int i = 0; i < 50; i++) begin
            if (op_valid) begin
                t = cyc;
                break;
            end
            @(negedge CLK);
        end
        if (t < 0) chk("op_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int t, tf, tv, tw, t1, t2;
        bit ga, gf;

        RST_N = 1'b0; init_phase = 1'b1;
        fetch_req = 0; src_a = 0; src_b = 0; op_ready = 0;
        wb_req = 0; wb_addr = 0; wb_data = 0;
        for (int i = 0; i < DEPTH; i++) begin
            init_vals[i] = DW'($urandom);
            shadow[i]    = init_vals[i];
        end
        init_vals[7] = 16'h0F0F;
        shadow[7]    = 16'h0F0F;
        model_reset();

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_reg_ce", 32'(reg_CE), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_op_a", 32'(op_a), 32'd0);
        chk("rst_op_b", 32'(op_b), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        init_phase = 1'b0;
        RST_N = 1'b1;
        chk_en = 1'b1;

        // Write 5 <- A5A5 then fetch 5,5
        op_ready = 1'b1;
        send_write(5'd5, 16'hA5A5, t);
        @(negedge CLK);
        chk("wr5_ce_high", 32'(reg_CE), 32'd1);
        chk("wr5_addr", 32'(reg_addr), 32'd5);
        @(negedge CLK);
        chk("wr5_ce_low", 32'(reg_CE), 32'd0);
        send_fetch(5'd5, 5'd5, tf);
        wait_valid(tv);
        chk("f55_latency", 32'(tv - tf), 32'd3);
        chk("f55_op_a", 32'(op_a), 32'hA5A5);
        chk("f55_op_b", 32'(op_b), 32'hA5A5);

        // Simultaneous write and fetch
        @(posedge CLK); #1;
        wb_req = 1; wb_addr = 5'd3; wb_data = 16'h1234;
        fetch_req = 1; src_a = 5'd3; src_b = 5'd7;
        @(negedge CLK);
        tw = cyc;
        chk("sim_wb_first", 32'(wb_ack), 32'd1);
        chk("sim_fetch_wait", 32'(fetch_ack), 32'd0);
        @(posedge CLK); #1;
        wb_req = 0;
        wait_fetch_ack(tf);
        chk("sim_fetch_gap", 32'(tf - tw), 32'd2);
        @(posedge CLK); #1;
        fetch_req = 0;
        wait_valid(tv);
        chk("sim_op_a", 32'(op_a), 32'h1234);
        chk("sim_op_b", 32'(op_b), 32'h0F0F);

        // Consumer stall in HOLD with pending requests
        @(posedge CLK); #1;
        op_ready = 1'b0;
        send_fetch(5'd1, 5'd2, tf);
        @(negedge CLK);
        wait_valid(tv);
        @(posedge CLK); #1;
        wb_req = 1; wb_addr = 5'd11; wb_data = 16'h5A5A;
        fetch_req = 1; src_a = 5'd6; src_b = 5'd8;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("hold_valid", 32'(op_valid), 32'd1);
            chk("hold_no_wb_ack", 32'(wb_ack), 32'd0);
            chk("hold_no_f_ack", 32'(fetch_ack), 32'd0);
            chk("hold_op_a", 32'(op_a), 32'(M_REG0 ? init_vals[1] : init_vals[1]));
            chk("hold_op_b", 32'(op_b), 32'(init_vals[2]));
        end
        @(posedge CLK); #1;
        op_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("hold_release_idle", 32'(busy), 32'd0);
        chk("hold_release_wb", 32'(wb_ack), 32'd1);
        @(posedge CLK); #1;
        wb_req = 0;
        wait_fetch_ack(tf);
        @(posedge CLK); #1;
        fetch_req = 0;
        repeat (4) @(posedge CLK);

        // Back-to-back fetches
        #1;
        fetch_req = 1; src_a = 5'd1; src_b = 5'd2;
        wait_fetch_ack(t1);
        @(posedge CLK); #1;
        src_a = 5'd3; src_b = 5'd4;
        wait_fetch_ack(t2);
        chk("b2b_gap", 32'(t2 - t1), 32'd4);
        @(posedge CLK); #1;
        fetch_req = 0;
        wait_valid(tv);
        chk("b2b_op_a", 32'(op_a), 32'h1234);
        chk("b2b_op_b", 32'(op_b), 32'(init_vals[4]));

        // Reset during WRITE
        send_write(5'd9, 16'hDEAD, t);
        chk("mid_ce_before", 32'(reg_CE), 32'd1);
        chk_en = 1'b0;
        #1 RST_N = 1'b0;
        #1;
        chk("mid_rst_ce", 32'(reg_CE), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(op_valid), 32'd0);
        @(posedge CLK);
        @(posedge CLK); #1;
        chk("mid_rst_bank", 32'(mem[9]), 32'(shadow[9]));
        RST_N = 1'b1;
        model_reset();
        chk_en = 1'b1;

        // Register 0 behaviour
        send_write(5'd0, 16'hFFFF, t);
        @(negedge CLK);
        chk("r0_ce", 32'(reg_CE), M_REG0 ? 32'd0 : 32'd1);
        send_fetch(5'd0, 5'd0, tf);
        @(negedge CLK);
        wait_valid(tv);
        chk("r0_op_a", 32'(op_a), M_REG0 ? 32'd0 : 32'hFFFF);

        // Randomized traffic
        ga = 0; gf = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge CLK); #1;
            if (ga) wb_req = 0;
            if (gf) fetch_req = 0;
            if (!wb_req && $urandom_range(0, 3) == 0) begin
                wb_req  = 1;
                wb_addr = AW'($urandom_range(0, DEPTH - 1));
                wb_data = DW'($urandom);
            end
            if (!fetch_req && $urandom_range(0, 2) == 0) begin
                fetch_req = 1;
                src_a = AW'($urandom_range(0, DEPTH - 1));
                src_b = ($urandom_range(0, 7) == 0) ? src_a : AW'($urandom_range(0, DEPTH - 1));
            end
            op_ready = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            ga = wb_ack;
            gf = fetch_ack;
        end
        @(posedge CLK); #1;
        wb_req = 0; fetch_req = 0; op_ready = 1;
        repeat (8) @(posedge CLK);
        #1;
        chk("end_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
